// File: rtl/bus_arbiter_2m_split.sv
// bus_arbiter_2m_split: two-master bus arbiter with split parking/resume and a hold watchdog.
// Define ARB_ROUND_ROBIN_EN to break ties toward the master not granted most recently.
module bus_arbiter_2m_split #(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 9
) (
   input  logic clk,
   input  logic rstn,
   input  logic m1_breq,
   input  logic m2_breq,
   input  logic s_split,
   input  logic s_split_ready,
   output logic m1_bgrant,
   output logic m2_bgrant,
   output logic msel,
   output logic m1_split,
   output logic m2_split,
   output logic split_grant,
   output logic timeout_err,
   output logic bus_busy
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] OWN_M1 = 2'd1;
   localparam logic [1:0] OWN_M2 = 2'd2;
   logic [1:0] state, pend, blk, br, elig;
   logic [CNT_W-1:0] cnt;
   logic park, resume, settle, go, who, own, wd, tie_m2;
   assign br     = {m2_breq, m1_breq};
   assign park   = pend[1];
   assign settle = |pend & s_split_ready;
   assign resume = settle & br[park];
   assign elig   = br & ~pend & ~blk;
   assign go     = resume | (~settle & |elig);
   assign who    = resume ? park : (&elig ? tie_m2 : elig[1]);
   assign own    = state == OWN_M2;
   assign wd     = TIMEOUT > 0 && cnt == CNT_W'(TIMEOUT - 1);
`ifdef ARB_ROUND_ROBIN_EN
   logic last;
   assign tie_m2 = ~last;
   always_ff @(posedge clk)
      if (!rstn) last <= 1'b1;
      else if (state == IDLE && go) last <= who;
`else
   assign tie_m2 = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         pend        <= 2'b00;
         blk         <= 2'b00;
         cnt         <= '0;
         msel        <= 1'b0;
         split_grant <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         blk         <= blk & br;
         if (state == IDLE) begin
            if (settle) pend <= 2'b00;
            if (go) begin
               state       <= who ? OWN_M2 : OWN_M1;
               msel        <= who;
               cnt         <= '0;
               split_grant <= resume;
            end
         end else if (!br[own]) begin
            state       <= IDLE;
            split_grant <= 1'b0;
         end else if (s_split && pend == 2'b00) begin
            state       <= IDLE;
            pend[own]   <= 1'b1;
            split_grant <= 1'b0;
         end else if (wd) begin
            // revoked owner stays blocked until it drops its request
            state       <= IDLE;
            timeout_err <= 1'b1;
            blk[own]    <= 1'b1;
            split_grant <= 1'b0;
         end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end
   end
   assign m1_bgrant = state == OWN_M1;
   assign m2_bgrant = state == OWN_M2;
   assign m1_split  = pend[0];
   assign m2_split  = pend[1];
   assign bus_busy  = m1_bgrant | m2_bgrant;
endmodule

// File: doc/bus_arbiter_2m_split.md
Name: bus_arbiter_2m_split

Overview:
- Registered arbiter sharing the serial system bus between two masters. Handles split transactions from the split-capable slave (slave 3).
- Drives grants, the master-side datapath select, per-master split flags and the slave-side split_grant.
- A hold watchdog revokes a grant when the owning master stalls the bus.
- Sits inside the 2-master/3-slave bus, ahead of the master/slave muxes.

Parameters:
- TIMEOUT, 256: cycles a master may hold a grant before forced revoke; 0 disables the watchdog.
- CNT_W, 9: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- m1_breq  in  1  master 1 bus request; held high for the whole transaction, low = release
- m2_breq  in  1  master 2 bus request
- s_split  in  1  one-cycle pulse from the addressed slave: current owner's transaction is split
- s_split_ready  in  1  split slave ready to complete the parked transaction; level
- m1_bgrant  out  1  master 1 owns the bus
- m2_bgrant  out  1  master 2 owns the bus
- msel  out  1  mux select, 0 = m1, 1 = m2; holds last owner when idle
- m1_split  out  1  master 1 parked on a split
- m2_split  out  1  master 2 parked on a split
- split_grant  out  1  bus currently re-granted to the parked (split) master
- timeout_err  out  1  one-cycle pulse on watchdog revoke
- bus_busy  out  1  some grant active

Behaviour:
- Reset: rstn is synchronous, active-low; clk is the clock. All outputs 0, state IDLE, split pending cleared, watchdog counter 0, block flags cleared. Reset mid-transaction drops grants on the next edge.
- States: IDLE, OWN_M1, OWN_M2. Split pending is a separate register: 2'b00 = none, 01 = m1 parked, 10 = m2 parked. At most one split outstanding.
- All outputs are registered. Grant is visible the cycle after the edge at which the request was sampled in IDLE. Latency from breq high to bgrant high is 1 cycle.
- Every exit from OWN_x passes through IDLE for exactly one cycle, so grants never switch back-to-back.
- IDLE selection priority, highest first:
  - (1) Resume: split pending, s_split_ready=1 and the parked master's breq=1. Grant the parked master, clear its mx_split, set split_grant=1.
  - (2) Both masters requesting, neither parked nor blocked: m1 wins (fixed priority).
  - (3) A single eligible requester is granted.
- A parked master's breq is ignored for normal arbitration.
- Cancel: split pending, s_split_ready=1 and the parked master's breq=0. Clear the pending flag, grant no one.
- OWN_x exits:
  - breq_x sampled 0: bgrant_x=0, split_grant=0, go to IDLE.
  - s_split=1 with no split pending: bgrant_x=0, mx_split=1, go to IDLE.
  - s_split=1 while a split is already pending: ignored, owner keeps the grant.
- Simultaneous events in OWN_x:
  - release and s_split in the same cycle: release wins, no split recorded.
  - s_split and watchdog expiry in the same cycle: split wins, no timeout_err.
  - s_split_ready during another master's ownership: no effect until that owner releases; resume then wins in IDLE over new requests.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to OWN_x and increments each cycle in OWN_x.
  - When the count reaches TIMEOUT-1 with breq_x still high, the next edge forces bgrant_x=0, pulses timeout_err for 1 cycle and enters IDLE.
  - The counter saturates and never wraps.
  - A revoked master is blocked from re-grant until it deasserts breq for at least one cycle.
  - Applies to resumed split grants too; a revoke then also clears split_grant.
- msel updates on the edge that grants and holds afterwards. bus_busy = m1_bgrant | m2_bgrant.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: rule (2) tie goes to the master not granted most recently. The last-owner register resets to m2, so the first tie goes to m1.
- Undefined: fixed priority, m1 wins every tie; last-owner register absent.

Test Plan:
- Both breq rise together at cycle 10 → m1_bgrant=1 from cycle 11, msel=0. m1 releases at cycle 20 → IDLE at cycle 21, m2_bgrant=1 at cycle 22, msel=1.
- m1 owns, s_split pulse at cycle 15 → m1_bgrant=0, m1_split=1 at cycle 16. m2 is granted at cycle 17. m2 releases at cycle 25 with s_split_ready=1 from cycle 20 → m1_bgrant=1, split_grant=1, m1_split=0 at cycle 27.
- TIMEOUT=8, m2 holds breq indefinitely → m2_bgrant high for exactly 8 cycles, then timeout_err pulse for 1 cycle. m2 is not re-granted until breq drops for at least one cycle.
- Release and s_split in the same cycle → no mx_split set, timeout_err=0. A second s_split while m1 is parked → current owner keeps its grant.
- rstn low mid-grant with m2 parked → next cycle all outputs 0 and pending cleared. After rstn high, s_split_ready has no effect.
- With ARB_ROUND_ROBIN_EN: three consecutive ties, each master releasing after 3 cycles → grant order m1, m2, m1. Without the macro → m1, m1, m1.
